ime_frame_arbiter: RTL and testbench

IME_FRAME_ARBITER -- requirements
Module: ime_frame_arbiter

---
 rtl/ime_frame_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ime_frame_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ime_frame_arbiter.sv
// ime_frame_arbiter: frame-atomic round-robin merge of a system stream (s0)
// and a BIST stream (s1) onto one AXI-Stream master.
// Optional feature macro: IME_ARB_WATCHDOG_EN adds a stall watchdog that
// forces a poisoned terminating beat (ABORT) and discards the rest of the
// stalled frame (DRAIN).
module ime_frame_arbiter #(
    parameter int W_DATA = 48,
    parameter int TO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [W_DATA-1:0] s0_axis_tdata,
    input  logic [7:0]        s0_axis_tuser,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,

    input  logic [W_DATA-1:0] s1_axis_tdata,
    input  logic [7:0]        s1_axis_tuser,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,

    output logic [W_DATA-1:0] m_axis_tdata,
    output logic [7:0]        m_axis_tuser,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              m_axis_tpoison,

    input  logic              bist_mode,
    input  logic [TO_W-1:0]   frame_timeout,
    output logic              grant_id,
    output logic              busy,
    output logic              timeout_pulse,
    output logic [15:0]       frame_cnt0,
    output logic [15:0]       frame_cnt1
);

`ifdef IME_ARB_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE, GRANT, ABORT, DRAIN} state_t;
`else
    typedef enum logic {IDLE, GRANT} state_t;
`endif

    state_t state, state_nxt;

    logic              elig0, elig1, any_req, pick;
    logic [W_DATA-1:0] sel_tdata;
    logic [7:0]        sel_tuser;
    logic              sel_tvalid, sel_tlast;
    logic              hs, frame_done;

`ifdef IME_ARB_WATCHDOG_EN
    logic [TO_W-1:0]   wd_cnt;
    logic              trip, drain_done;
`else
    logic              unused_frame_timeout;
    assign unused_frame_timeout = ^frame_timeout;
    assign timeout_pulse        = 1'b0;
`endif

    // Request eligibility, round-robin pick and the granted-source mux
    always_comb begin
        elig0      = s0_axis_tvalid & ~bist_mode;
        elig1      = s1_axis_tvalid;
        any_req    = elig0 | elig1;
        if (elig0 && elig1)
            pick = ~grant_id;
        else
            pick = elig1;
        sel_tdata  = grant_id ? s1_axis_tdata  : s0_axis_tdata;
        sel_tuser  = grant_id ? s1_axis_tuser  : s0_axis_tuser;
        sel_tvalid = grant_id ? s1_axis_tvalid : s0_axis_tvalid;
        sel_tlast  = grant_id ? s1_axis_tlast  : s0_axis_tlast;
        hs         = (state == GRANT) && sel_tvalid && m_axis_tready;
        frame_done = hs && sel_tlast;
`ifdef IME_ARB_WATCHDOG_EN
        trip       = (state == GRANT) && !hs && (frame_timeout != '0) &&
                     (wd_cnt == frame_timeout);
        drain_done = (state == DRAIN) && sel_tvalid && sel_tlast;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = GRANT;
            end
            GRANT: begin
                if (frame_done)
                    state_nxt = IDLE;
`ifdef IME_ARB_WATCHDOG_EN
                else if (trip)
                    state_nxt = ABORT;
`endif
            end
`ifdef IME_ARB_WATCHDOG_EN
            ABORT: begin
                if (m_axis_tready)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done)
                    state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: pass-through in GRANT, forced poison beat in ABORT,
    // silent discard of the stalled source in DRAIN
    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tuser   = 8'h00;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tpoison = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        busy           = (state != IDLE);
        case (state)
            GRANT: begin
                m_axis_tdata   = sel_tdata;
                m_axis_tuser   = sel_tuser;
                m_axis_tvalid  = sel_tvalid;
                m_axis_tlast   = sel_tlast;
                s0_axis_tready = m_axis_tready & ~grant_id;
                s1_axis_tready = m_axis_tready & grant_id;
            end
`ifdef IME_ARB_WATCHDOG_EN
            ABORT: begin
                m_axis_tvalid  = 1'b1;
                m_axis_tuser   = 8'hFF;
                m_axis_tlast   = 1'b1;
                m_axis_tpoison = 1'b1;
            end
            DRAIN: begin
                s0_axis_tready = ~grant_id;
                s1_axis_tready = grant_id;
            end
`endif
            default: ;
        endcase
    end

    // Grant owner: only moves when a new frame is granted out of IDLE;
    // reset value 1 lets s0 win the first tie
    always_ff @(posedge clk) begin
        if (rst)
            grant_id <= 1'b1;
        else if (state == IDLE && any_req)
            grant_id <= pick;
    end

    // Saturating completed-frame counters, bumped on the accepted tlast beat
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt0 <= 16'h0000;
            frame_cnt1 <= 16'h0000;
        end else if (frame_done) begin
            if (grant_id) begin
                if (frame_cnt1 != 16'hFFFF)
                    frame_cnt1 <= frame_cnt1 + 16'd1;
            end else begin
                if (frame_cnt0 != 16'hFFFF)
                    frame_cnt0 <= frame_cnt0 + 16'd1;
            end
        end
    end

`ifdef IME_ARB_WATCHDOG_EN
    // Stall watchdog: counts GRANT cycles without a handshake, clears on
    // any handshake or outside GRANT; timeout_pulse marks the ABORT entry
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt        <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= trip;
            if (state != GRANT || hs || trip)
                wd_cnt <= '0;
            else if (wd_cnt != '1)
                wd_cnt <= wd_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_ime_frame_arbiter.sv
// tb_ime_frame_arbiter: directed scoreboard bench for ime_frame_arbiter.
// Builds with or without IME_ARB_WATCHDOG_EN; watchdog expectations follow
// the macro.
module tb_ime_frame_arbiter;

    localparam int W_DATA = 48;
    localparam int TO_W   = 16;
`ifdef IME_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [W_DATA-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [7:0]        s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
    logic              s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic              s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
    logic              s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic              m_axis_tpoison, bist_mode, grant_id, busy, timeout_pulse;
    logic [TO_W-1:0]   frame_timeout;
    logic [15:0]       frame_cnt0, frame_cnt1;

    typedef struct packed {
        logic [47:0] data;
        logic [7:0]  user;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [47:0] data;
        logic [7:0]  user;
        logic        last;
        logic        poison;
    } exp_t;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  expq[$];
    int    hs_cyc[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    tp_cnt   = 0;
    int    pz_cnt   = 0;

    ime_frame_arbiter #(.W_DATA(W_DATA), .TO_W(TO_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tready (s0_axis_tready),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tpoison (m_axis_tpoison),
        .bist_mode      (bist_mode),
        .frame_timeout  (frame_timeout),
        .grant_id       (grant_id),
        .busy           (busy),
        .timeout_pulse  (timeout_pulse),
        .frame_cnt0     (frame_cnt0),
        .frame_cnt1     (frame_cnt1)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Cycle index used to measure beat spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Hang guard
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1, "[TB] aborted");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // Queue a slice of a frame on a source and/or its expected merged beats
    task automatic applyStimulus(input int src, input int tag, input int first,
                                 input int count, input int total,
                                 input bit to_source, input bit to_expect);
        for (int b = first; b < first + count; b++) begin
            beat_t bt;
            exp_t  e;
            bt.data = {16'(tag), 16'(src), 16'(b)};
            bt.user = 8'(tag * 16 + b);
            bt.last = (b == total - 1);
            if (to_source) begin
                if (src == 0) q0.push_back(bt);
                else          q1.push_back(bt);
            end
            if (to_expect) begin
                e.data   = bt.data;
                e.user   = bt.user;
                e.last   = bt.last;
                e.poison = 1'b0;
                expq.push_back(e);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic waitDrain(input int limit, input bit ignore_q0);
        bit ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (expq.size() == 0 && !busy && q1.size() == 0 &&
                (ignore_q0 || q0.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("drain_within_budget", 64'(ok), 64'd1);
    endtask

    // Source drivers: pop on an observed handshake, then present the head beat
    initial begin
        bit h0, h1;
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            h0 = s0_axis_tvalid && s0_axis_tready;
            h1 = s1_axis_tvalid && s1_axis_tready;
            @(posedge clk);
            #1;
            if (h0 && q0.size() > 0) void'(q0.pop_front());
            if (h1 && q1.size() > 0) void'(q1.pop_front());
            #2;
            if (q0.size() > 0) begin
                s0_axis_tvalid = 1'b1; s0_axis_tdata = q0[0].data;
                s0_axis_tuser  = q0[0].user; s0_axis_tlast = q0[0].last;
            end else begin
                s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
            end
            if (q1.size() > 0) begin
                s1_axis_tvalid = 1'b1; s1_axis_tdata = q1[0].data;
                s1_axis_tuser  = q1[0].user; s1_axis_tlast = q1[0].last;
            end else begin
                s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
            end
        end
    end

    // Monitor: scoreboard pop on every master handshake, stability under stall
    initial begin
        bit          held = 1'b0;
        logic [57:0] held_val = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (timeout_pulse)  tp_cnt++;
            if (m_axis_tpoison) pz_cnt++;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                checkOutput("stall_tvalid_held", 64'(m_axis_tvalid), 64'd1);
                checkOutput("stall_beat_stable",
                            64'({m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tpoison}),
                            64'(held_val));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cyc.push_back(cyc);
                checkOutput("scoreboard_has_entry", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checkOutput("beat_tdata",   64'(m_axis_tdata),   64'(e.data));
                    checkOutput("beat_tuser",   64'(m_axis_tuser),   64'(e.user));
                    checkOutput("beat_tlast",   64'(m_axis_tlast),   64'(e.last));
                    checkOutput("beat_tpoison", 64'(m_axis_tpoison), 64'(e.poison));
                end
            end
            held     = m_axis_tvalid && !m_axis_tready;
            held_val = {m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tpoison};
        end
    end

    // Directed sequence
    initial begin
        exp_t ab;
        rst = 1'b1; m_axis_tready = 1'b0; bist_mode = 1'b0; frame_timeout = '0;

        // Reset state
        repeat (3) tick();
        #2;
        checkOutput("rst_m_tvalid",  64'(m_axis_tvalid),  64'd0);
        checkOutput("rst_m_tdata",   64'(m_axis_tdata),   64'd0);
        checkOutput("rst_m_tlast",   64'(m_axis_tlast),   64'd0);
        checkOutput("rst_m_tpoison", 64'(m_axis_tpoison), 64'd0);
        checkOutput("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
        checkOutput("rst_s1_tready", 64'(s1_axis_tready), 64'd0);
        checkOutput("rst_busy",      64'(busy),           64'd0);
        checkOutput("rst_tpulse",    64'(timeout_pulse),  64'd0);
        checkOutput("rst_grant_id",  64'(grant_id),       64'd1);
        checkOutput("rst_cnt0",      64'(frame_cnt0),     64'd0);
        checkOutput("rst_cnt1",      64'(frame_cnt1),     64'd0);
        rst = 1'b0;
        m_axis_tready = 1'b1;

        // Single source, 4-beat frame
        tick();
        hs_cyc.delete();
        applyStimulus(0, 1, 0, 4, 4, 1, 1);
        waitDrain(50, 0);
        checkOutput("single_cnt0",     64'(frame_cnt0),    64'd1);
        checkOutput("single_grant_id", 64'(grant_id),      64'd0);
        checkOutput("single_beats",    64'(hs_cyc.size()), 64'd4);
        checkOutput("single_span",     64'(hs_cyc[3] - hs_cyc[0]), 64'd3);

        // Contention after a fresh reset: s0, bubble, s1, bubble, s0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hs_cyc.delete();
        applyStimulus(0, 2, 0, 2, 2, 1, 1);
        applyStimulus(1, 3, 0, 3, 3, 1, 1);
        applyStimulus(0, 4, 0, 2, 2, 1, 1);
        waitDrain(100, 0);
        checkOutput("rr_beats",    64'(hs_cyc.size()), 64'd7);
        checkOutput("rr_span",     64'(hs_cyc[6] - hs_cyc[0]), 64'd8);
        checkOutput("rr_cnt0",     64'(frame_cnt0), 64'd2);
        checkOutput("rr_cnt1",     64'(frame_cnt1), 64'd1);
        checkOutput("rr_grant_id", 64'(grant_id),   64'd0);

        // BIST asserted mid s0 frame: s0 completes, then only s1 granted
        applyStimulus(0, 5, 0, 4, 4, 1, 1);
        tick();
        tick();
        checkOutput("bist_midframe_busy",  64'(busy),     64'd1);
        checkOutput("bist_midframe_grant", 64'(grant_id), 64'd0);
        bist_mode = 1'b1;
        applyStimulus(1, 6, 0, 2, 2, 1, 1);
        applyStimulus(1, 7, 0, 3, 3, 1, 1);
        applyStimulus(0, 8, 0, 2, 2, 1, 0);
        waitDrain(100, 1);
        repeat (5) tick();
        #2;
        checkOutput("bist_cnt0",      64'(frame_cnt0),     64'd3);
        checkOutput("bist_cnt1",      64'(frame_cnt1),     64'd3);
        checkOutput("bist_s0_masked", 64'(busy),           64'd0);
        checkOutput("bist_s0_tready", 64'(s0_axis_tready), 64'd0);
        checkOutput("bist_s0_pending", 64'(q0.size()),     64'd2);
        bist_mode = 1'b0;
        applyStimulus(0, 8, 0, 2, 2, 0, 1);
        waitDrain(50, 0);
        checkOutput("bist_off_cnt0", 64'(frame_cnt0), 64'd4);

        // Backpressure: tready toggles, granted tready mirrors it
        hs_cyc.delete();
        applyStimulus(1, 9, 0, 4, 4, 1, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            m_axis_tready = (i % 2 == 0);
            #2;
            if (busy) begin
                checkOutput("bp_s1_tready", 64'(s1_axis_tready), 64'(m_axis_tready));
                checkOutput("bp_s0_tready", 64'(s0_axis_tready), 64'd0);
            end
        end
        m_axis_tready = 1'b1;
        waitDrain(50, 0);
        checkOutput("bp_cnt1",  64'(frame_cnt1),    64'd4);
        checkOutput("bp_beats", 64'(hs_cyc.size()), 64'd4);

        // Watchdog: s1 stalls after two beats with frame_timeout=8
        hs_cyc.delete();
        tp_cnt = 0;
        pz_cnt = 0;
        frame_timeout = 16'd8;
        applyStimulus(1, 10, 0, 2, 5, 1, 1);
`ifdef IME_ARB_WATCHDOG_EN
        ab.data = '0; ab.user = 8'hFF; ab.last = 1'b1; ab.poison = 1'b1;
        expq.push_back(ab);
`endif
        repeat (20) tick();
        checkOutput("wd_tpulse_cnt", 64'(tp_cnt), WD ? 64'd1 : 64'd0);
        checkOutput("wd_poison_cnt", 64'(pz_cnt), WD ? 64'd1 : 64'd0);
        checkOutput("wd_busy",       64'(busy),   64'd1);
        applyStimulus(1, 10, 2, 3, 5, 1, !WD);
        waitDrain(50, 0);
        checkOutput("wd_cnt1",  64'(frame_cnt1),    WD ? 64'd4 : 64'd5);
        checkOutput("wd_beats", 64'(hs_cyc.size()), WD ? 64'd3 : 64'd5);

        // Disabled watchdog: 1000-cycle stall never aborts
        frame_timeout = '0;
        tp_cnt = 0;
        pz_cnt = 0;
        applyStimulus(0, 11, 0, 2, 3, 1, 1);
        repeat (1000) tick();
        checkOutput("nowd_busy",   64'(busy),   64'd1);
        checkOutput("nowd_tpulse", 64'(tp_cnt), 64'd0);
        checkOutput("nowd_poison", 64'(pz_cnt), 64'd0);
        applyStimulus(0, 11, 2, 1, 3, 1, 1);
        waitDrain(50, 0);
        checkOutput("nowd_cnt0", 64'(frame_cnt0), 64'd5);

        // Reset mid-frame: two beats pass, then the frame is abandoned
        applyStimulus(0, 12, 0, 4, 4, 1, 0);
        applyStimulus(0, 12, 0, 2, 4, 0, 1);
        repeat (3) tick();
        rst = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        q0.delete();
        #2;
        checkOutput("midrst_m_tvalid",  64'(m_axis_tvalid),  64'd0);
        checkOutput("midrst_m_tdata",   64'(m_axis_tdata),   64'd0);
        checkOutput("midrst_m_tlast",   64'(m_axis_tlast),   64'd0);
        checkOutput("midrst_m_tpoison", 64'(m_axis_tpoison), 64'd0);
        checkOutput("midrst_s0_tready", 64'(s0_axis_tready), 64'd0);
        checkOutput("midrst_busy",      64'(busy),           64'd0);
        checkOutput("midrst_cnt0",      64'(frame_cnt0),     64'd0);
        checkOutput("midrst_cnt1",      64'(frame_cnt1),     64'd0);
        checkOutput("midrst_grant_id",  64'(grant_id),       64'd1);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        checkOutput("midrst_idle_after", 64'(busy),        64'd0);
        checkOutput("scoreboard_empty",  64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
